// File: rtl/biquad_iir_core.sv
// Direct-form-I biquad filter built around one time-shared multiplier.
// Each accepted sample takes five MAC cycles (b10, b11, b12, a11, a12 taps),
// then the rounded and saturated result is held until the sink accepts it.
module biquad_iir_core #(
    parameter int DW        = 16,
    parameter int COEF_FRAC = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clear_i,
    input  logic [DW-1:0] a11_i,
    input  logic [DW-1:0] a12_i,
    input  logic [DW-1:0] b10_i,
    input  logic [DW-1:0] b11_i,
    input  logic [DW-1:0] b12_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] x_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] y_o,
    output logic          ovf_o
);

    localparam int PW = 2 * DW;
    localparam int AW = 2 * DW + 3;

    localparam logic signed [AW-1:0] RND_BIAS = AW'(1) << (COEF_FRAC - 1);
    localparam logic signed [AW-1:0] SAT_MAX  = (AW'(1) << (DW - 1)) - AW'(1);
    localparam logic signed [AW-1:0] SAT_MIN  = -(AW'(1) << (DW - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [2:0]            tap_q;
    logic signed [AW-1:0]  acc_q;

    logic signed [DW-1:0]  x_q;
    logic signed [DW-1:0]  x1_q;
    logic signed [DW-1:0]  x2_q;
    logic signed [DW-1:0]  y1_q;
    logic signed [DW-1:0]  y2_q;

    logic signed [DW-1:0]  c_a11_q;
    logic signed [DW-1:0]  c_a12_q;
    logic signed [DW-1:0]  c_b10_q;
    logic signed [DW-1:0]  c_b11_q;
    logic signed [DW-1:0]  c_b12_q;

    logic signed [DW-1:0]  coef_sel;
    logic signed [DW-1:0]  data_sel;
    logic signed [PW-1:0]  coef_ext;
    logic signed [PW-1:0]  data_ext;
    logic signed [PW-1:0]  product;
    logic signed [AW-1:0]  sum;
    logic signed [AW-1:0]  sum_rnd;
    logic signed [AW-1:0]  shifted;
    logic signed [DW-1:0]  y_sat;
    logic                  y_ovf;

    // Handshake flags are pure decodes of the registered state.
    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == OUT);

    // Select the coefficient/data pair for the current tap and form the running sum.
    always_comb begin
        coef_sel = '0;
        data_sel = '0;
        case (tap_q)
            3'd0: begin coef_sel = c_b10_q; data_sel = x_q;  end
            3'd1: begin coef_sel = c_b11_q; data_sel = x1_q; end
            3'd2: begin coef_sel = c_b12_q; data_sel = x2_q; end
            3'd3: begin coef_sel = c_a11_q; data_sel = y1_q; end
            3'd4: begin coef_sel = c_a12_q; data_sel = y2_q; end
            default: begin coef_sel = '0; data_sel = '0; end
        endcase
        coef_ext = {{DW{coef_sel[DW-1]}}, coef_sel};
        data_ext = {{DW{data_sel[DW-1]}}, data_sel};
        product  = coef_ext * data_ext;
        sum      = acc_q + {{(AW-PW){product[PW-1]}}, product};
    end

    // Round half toward +inf, drop the fractional bits, then clamp to the sample range.
    always_comb begin
        sum_rnd = sum + RND_BIAS;
        shifted = sum_rnd >>> COEF_FRAC;
        y_sat   = shifted[DW-1:0];
        y_ovf   = 1'b0;
        if (shifted > SAT_MAX) begin
            y_sat = SAT_MAX[DW-1:0];
            y_ovf = 1'b1;
        end else if (shifted < SAT_MIN) begin
            y_sat = SAT_MIN[DW-1:0];
            y_ovf = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides any handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid_i)    state_d = MAC;
            MAC:     if (tap_q == 3'd4) state_d = OUT;
            OUT:     if (out_ready_i)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d = IDLE;
        end
    end

    // Datapath: latch the sample and coefficients, accumulate taps, publish the result and shift history.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tap_q   <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            c_a11_q <= '0;
            c_a12_q <= '0;
            c_b10_q <= '0;
            c_b11_q <= '0;
            c_b12_q <= '0;
            y_o     <= '0;
            ovf_o   <= 1'b0;
        end else if (clear_i) begin
            tap_q   <= '0;
            acc_q   <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            y_o     <= '0;
            ovf_o   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        x_q     <= x_i;
                        c_a11_q <= a11_i;
                        c_a12_q <= a12_i;
                        c_b10_q <= b10_i;
                        c_b11_q <= b11_i;
                        c_b12_q <= b12_i;
                        acc_q   <= '0;
                        tap_q   <= '0;
                    end
                end
                MAC: begin
                    if (tap_q == 3'd4) begin
                        y_o   <= y_sat;
                        ovf_o <= y_ovf;
                        x2_q  <= x1_q;
                        x1_q  <= x_q;
                        y2_q  <= y1_q;
                        y1_q  <= y_sat;
                        tap_q <= '0;
                    end else begin
                        acc_q <= sum;
                        tap_q <= tap_q + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/biquad_iir_core.md
# biquad_iir_core

- Second-order IIR filter (biquad, direct form I) that consumes the five 16-bit coefficient registers `a11`, `a12`, `b10`, `b11`, `b12` published by the coefficient register block.
- Filters a stream of signed 16-bit samples.
- One time-shared multiplier produces one output per input sample, using valid/ready handshakes on both sides.
- Sits directly downstream of the coefficient register file, between the sample source and the sample sink.

## Interface

**Parameters**

- `DW`, 16 — sample and coefficient width, signed two's complement.
- `COEF_FRAC`, 8 — fractional bits of coefficients (default format Q7.8).

**Ports**

- `clk_i`  in  1  — clock; all state updates on its rising edge.
- `rst_n_i`  in  1  — reset, asynchronous, active-low.
- `clear_i`  in  1  — synchronous clear of history and in-flight computation.
- `a11_i`, `a12_i`  in  DW each — feedback coefficients for y[n-1], y[n-2]; stored pre-negated and added.
- `b10_i`, `b11_i`, `b12_i`  in  DW each — feedforward coefficients for x[n], x[n-1], x[n-2].
- `in_valid_i`  in  1  — input sample valid.
- `in_ready_o`  out  1  — core can accept a sample.
- `x_i`  in  DW  — input sample.
- `out_valid_o`  out  1  — output sample valid.
- `out_ready_i`  in  1  — sink accepts the output.
- `y_o`  out  DW  — output sample.
- `ovf_o`  out  1  — saturation occurred on `y_o`; qualified by `out_valid_o`.

## Operation

- Equation: y[n] = sat(round((b10·x[n] + b11·x[n-1] + b12·x[n-2] + a11·y[n-1] + a12·y[n-2]) >>> COEF_FRAC)).
- Products are full 2·DW signed.
- Accumulator is 2·DW+3 bits signed; it never wraps.
- Rounding: add 2^(COEF_FRAC-1), then arithmetic shift right (round half toward +inf).
- Saturation: clamp to [-2^(DW-1), 2^(DW-1)-1]; `ovf_o`=1 iff clamped.
- FSM states:
  - IDLE: `in_ready_o`=1. On in_valid&in_ready: latch `x_i` and all five coefficients, clear acc, tap=0, go to MAC.
  - MAC: one product per cycle, taps in order b10·x, b11·x1, b12·x2, a11·y1, a12·y2. On tap 4, the final sum (acc + product) is rounded and saturated into `y_o`/`ovf_o`, then go to OUT.
  - OUT: `out_valid_o`=1; `y_o` and `ovf_o` are held stable. On out_valid&out_ready: go to IDLE.
- History update occurs when leaving MAC: x2←x1, x1←x, y2←y1, y1←saturated y.
- Coefficient changes while in MAC or OUT do not affect the current sample; they apply from the next accepted sample.
- `clear_i`=1 at any state:
  - next state IDLE;
  - x1, x2, y1, y2 and acc zeroed;
  - `out_valid_o`=0, `y_o`=0, `ovf_o`=0;
  - any in-flight sample is discarded.
  - `clear_i` takes priority over a simultaneous input or output handshake.
- Reset values: state IDLE; `in_ready_o`=1, `out_valid_o`=0, `y_o`=0, `ovf_o`=0; all history and acc 0.

## Timing

- Input accepted at edge E0.
- Products accumulate at edges E1..E4; the final tap is summed and registered at E5.
- `out_valid_o` is high from after E5; latency is 5 cycles.
- If `out_ready_i` is high at E6: output is consumed, and `in_ready_o` is high after E6.
- Next input can be accepted at E7. Peak throughput is 1 sample per 7 cycles.
- Output backpressure holds OUT indefinitely; `in_ready_o`=0 throughout.
- `in_ready_o` and `out_valid_o` are registered state decodes with no combinational path from `in_valid_i` or `out_ready_i`.
- Asserting `rst_n_i` mid-operation immediately forces reset values. Deassertion is synchronized externally.

## Test plan

- **Pass-through:** b10=256, others 0; x=1000 → y=1000, ovf=0, `out_valid_o` rises 5 cycles after accept.
- **Delay:** b11=256, others 0; x=5 then 7 → y=0 then 5.
- **Feedback decay:** b10=256, a11=128, others 0; x=256,0,0,0 → y=256,128,64,32.
- **Saturation:**
  - b10=0x7FFF, x=0x7FFF → y=0x7FFF, ovf=1.
  - b10=0x7FFF, x=-32768 → y=-32768, ovf=1.
- **Reset coefficients:** b10=127, others 0 → x=256 gives y=127.
- **Backpressure, clear, mid-computation changes:**
  - Hold `out_ready_i`=0 for 10 cycles → `y_o` stable, `in_ready_o`=0.
  - Assert `clear_i` in MAC → IDLE next cycle, no output; next x=1000 with pass-through coefficients → y=1000 (history cleared).
  - Change b10 during MAC → current y uses the latched value.
